pfqueue: RTL and testbench

Instruction queue sitting between the prefetch cache and the instruction decoder. It accepts instruction/PC/illegal triples from the prefetch stage whenever it has room and presents them in order to the decoder, decoupling decoder stalls from cache lookups. The queue flushes completely on a branch or cache clear, and it stops accepting instructions after a bus-error (illegal) entry until the next flush.

---
 rtl/pfqueue.sv | 89 ++++++++
 tb/tb_pfqueue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pfqueue.sv
// pfqueue: in-order instruction queue between the prefetch cache and the
// decoder. Entries {illegal, pc, instruction} live in a small circular buffer
// addressed by LGDEPTH+1 bit pointers; the extra MSB separates full from
// empty. A bus-error entry poisons the queue so nothing further is accepted
// until a flush, while entries ahead of it still drain normally.
//
// Handshake: upstream transfers when i_v && o_stall_n; the decoder takes the
// head when o_v && i_stall_n. o_stall_n and all head outputs depend only on
// registered state, never on i_v or i_stall_n in the same cycle.
module pfqueue #(
  parameter int LGDEPTH = 2,
  parameter int AW      = 24,
  parameter int BUSW    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_v,
  input  logic [BUSW-1:0]    i_i,
  input  logic [AW-1:0]      i_pc,
  input  logic               i_illegal,
  output logic               o_stall_n,
  output logic               o_v,
  output logic [BUSW-1:0]    o_i,
  output logic [AW-1:0]      o_pc,
  output logic               o_illegal,
  input  logic               i_stall_n,
  output logic [LGDEPTH:0]   o_fill
);

  localparam int                D       = 1 << LGDEPTH;
  localparam int                EW      = 1 + AW + BUSW;
  localparam logic [LGDEPTH:0]  FULL_LV = (LGDEPTH+1)'(D);
  localparam logic [LGDEPTH:0]  PTR_ONE = (LGDEPTH+1)'(1);
  localparam logic [BUSW-1:0]   NOOP    = BUSW'(32'h7600_0000);

  logic [LGDEPTH:0] wrptr;
  logic [LGDEPTH:0] rdptr;
  logic             poisoned;
  logic [EW-1:0]    mem [D];
  logic [EW-1:0]    head;
  logic             full;
  logic             push;
  logic             pop;

  // Occupancy and flow control derived from registered state only.
  always_comb begin
    o_fill    = wrptr - rdptr;
    full      = (o_fill == FULL_LV);
    o_v       = (o_fill != '0);
    o_stall_n = !full && !poisoned;
    push      = i_v && o_stall_n && !i_flush && i_rst_n;
    pop       = o_v && i_stall_n && !i_flush && i_rst_n;
  end

  // Pointer and poison bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      wrptr    <= '0;
      rdptr    <= '0;
      poisoned <= 1'b0;
    end else begin
      if (push) begin
        wrptr <= wrptr + PTR_ONE;
        if (i_illegal) poisoned <= 1'b1;
      end
      if (pop) rdptr <= rdptr + PTR_ONE;
    end
  end

  // Storage write; no reset so the array maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wrptr[LGDEPTH-1:0]] <= {i_illegal, i_pc, i_i};
  end

  // Head presentation: stored entry when valid, otherwise a NOOP at PC 0.
  always_comb begin
    head      = mem[rdptr[LGDEPTH-1:0]];
    o_i       = NOOP;
    o_pc      = '0;
    o_illegal = 1'b0;
    if (o_v) begin
      o_i       = head[BUSW-1:0];
      o_pc      = head[AW+BUSW-1:BUSW];
      o_illegal = head[EW-1];
    end
  end

endmodule

// File: tb/tb_pfqueue.sv
// tb_pfqueue: table-driven vectors, hand-written corner sequences and a
// randomized phase checked against a queue-based reference model.
module tb_pfqueue;

  localparam int LGDEPTH = 2;
  localparam int AW      = 24;
  localparam int BUSW    = 32;
  localparam int D       = 1 << LGDEPTH;
  localparam int EW      = 1 + AW + BUSW;
  localparam logic [BUSW-1:0] NOOP = 32'h7600_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rst_n;
  logic               i_flush;
  logic               i_v;
  logic [BUSW-1:0]    i_i;
  logic [AW-1:0]      i_pc;
  logic               i_illegal;
  logic               o_stall_n;
  logic               o_v;
  logic [BUSW-1:0]    o_i;
  logic [AW-1:0]      o_pc;
  logic               o_illegal;
  logic               i_stall_n;
  logic [LGDEPTH:0]   o_fill;

  pfqueue #(.LGDEPTH(LGDEPTH), .AW(AW), .BUSW(BUSW)) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_flush),
    .i_v       (i_v),
    .i_i       (i_i),
    .i_pc      (i_pc),
    .i_illegal (i_illegal),
    .o_stall_n (o_stall_n),
    .o_v       (o_v),
    .o_i       (o_i),
    .o_pc      (o_pc),
    .o_illegal (o_illegal),
    .i_stall_n (i_stall_n),
    .o_fill    (o_fill)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  bit m_poison = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Model one clock edge from the current inputs: a list of entries, a
  // poison flag, capacity D.
  task automatic model_edge();
    int sz = exp_q.size();
    bit accept = (sz < D) && !m_poison;
    if (!i_rst_n || i_flush) begin
      exp_q.delete();
      m_poison = 1'b0;
    end else begin
      if (sz > 0 && i_stall_n) void'(exp_q.pop_front());
      if (i_v && accept) begin
        exp_q.push_back({i_illegal, i_pc, i_i});
        if (i_illegal) m_poison = 1'b1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    bit ev = (exp_q.size() != 0);
    logic [EW-1:0] e = ev ? exp_q[0] : {1'b0, {AW{1'b0}}, NOOP};
    chk({tag, "_v"},     64'(o_v),       64'(ev));
    chk({tag, "_fill"},  64'(o_fill),    64'(exp_q.size()));
    chk({tag, "_stall"}, 64'(o_stall_n), 64'((exp_q.size() < D) && !m_poison));
    chk({tag, "_pc"},    64'(o_pc),      64'(e[AW+BUSW-1:BUSW]));
    chk({tag, "_i"},     64'(o_i),       64'(e[BUSW-1:0]));
    chk({tag, "_ill"},   64'(o_illegal), 64'(e[EW-1]));
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [BUSW-1:0] instr_of(input logic [AW-1:0] pc);
    return 32'hC000_0000 | BUSW'(pc);
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst_n, input logic flush, input logic v,
                       input logic [AW-1:0] pc, input logic ill, input logic dec);
    i_rst_n   = rst_n;
    i_flush   = flush;
    i_v       = v;
    i_pc      = pc;
    i_i       = instr_of(pc);
    i_illegal = ill;
    i_stall_n = dec;
    step();
  endtask

  // Explicit expected state after an edge; o_i follows from v and pc.
  task automatic check_state(input string tag, input logic ev, input int efill,
                             input logic es, input logic [AW-1:0] epc, input logic eill);
    chk({tag, "_v"},     64'(o_v),       64'(ev));
    chk({tag, "_fill"},  64'(o_fill),    64'(efill));
    chk({tag, "_stall"}, 64'(o_stall_n), 64'(es));
    chk({tag, "_pc"},    64'(o_pc),      64'(ev ? epc : '0));
    chk({tag, "_i"},     64'(o_i),       64'(ev ? instr_of(epc) : NOOP));
    chk({tag, "_ill"},   64'(o_illegal), 64'(ev ? eill : 1'b0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string          name;
    logic           rst_n, flush, v, ill, dec;
    logic [AW-1:0]  pc;
    logic           ev, es, eill;
    int             efill;
    logic [AW-1:0]  epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst_n, input logic flush, input logic v,
                     input logic [AW-1:0] pc, input logic ill, input logic dec,
                     input logic ev, input int efill, input logic es,
                     input logic [AW-1:0] epc, input logic eill);
    vec_t t;
    t.name = name; t.rst_n = rst_n; t.flush = flush; t.v = v; t.pc = pc;
    t.ill = ill; t.dec = dec; t.ev = ev; t.efill = efill; t.es = es;
    t.epc = epc; t.eill = eill;
    vecs.push_back(t);
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_v = 1'b0; i_pc = '0;
    i_i = '0; i_illegal = 1'b0; i_stall_n = 1'b0;

    //   name        rst fl  v  pc      il dec  ev fill st epc     eill
    add("reset",     0, 0, 1, 24'h0AA, 0, 1,   0, 0, 1, 24'h000, 0);
    add("fill0",     1, 0, 1, 24'h100, 0, 0,   1, 1, 1, 24'h100, 0);
    add("fill1",     1, 0, 1, 24'h101, 0, 0,   1, 2, 1, 24'h100, 0);
    add("fill2",     1, 0, 1, 24'h102, 0, 0,   1, 3, 1, 24'h100, 0);
    add("fill3",     1, 0, 1, 24'h103, 0, 0,   1, 4, 0, 24'h100, 0);
    add("full_rej",  1, 0, 1, 24'h104, 0, 0,   1, 4, 0, 24'h100, 0);
    add("drain0",    1, 0, 0, 24'h000, 0, 1,   1, 3, 1, 24'h101, 0);
    add("drain1",    1, 0, 0, 24'h000, 0, 1,   1, 2, 1, 24'h102, 0);
    add("drain2",    1, 0, 0, 24'h000, 0, 1,   1, 1, 1, 24'h103, 0);
    add("drain3",    1, 0, 0, 24'h000, 0, 1,   0, 0, 1, 24'h000, 0);
    add("p_flush",   1, 1, 0, 24'h000, 0, 0,   0, 0, 1, 24'h000, 0);
    add("p_300",     1, 0, 1, 24'h300, 0, 0,   1, 1, 1, 24'h300, 0);
    add("p_301ill",  1, 0, 1, 24'h301, 1, 0,   1, 2, 0, 24'h300, 0);
    add("p_302rej",  1, 0, 1, 24'h302, 0, 0,   1, 2, 0, 24'h300, 0);
    add("p_pop300",  1, 0, 1, 24'h302, 0, 1,   1, 1, 0, 24'h301, 1);
    add("p_pop301",  1, 0, 1, 24'h302, 0, 1,   0, 0, 0, 24'h000, 0);
    add("p_unpois",  1, 1, 1, 24'h302, 0, 1,   0, 0, 1, 24'h000, 0);
    add("p_again",   1, 0, 1, 24'h303, 0, 0,   1, 1, 1, 24'h303, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst_n, vecs[k].flush, vecs[k].v, vecs[k].pc, vecs[k].ill, vecs[k].dec);
      check_state(vecs[k].name, vecs[k].ev, vecs[k].efill, vecs[k].es, vecs[k].epc, vecs[k].eill);
    end

    // Streaming: one push and one pop every cycle, across several wraps.
    drive(1, 1, 0, 24'h0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 1, 24'(24'h400 + k), 0, 1);
      chk($sformatf("stream%0d_v", k),    64'(o_v),    64'd1);
      chk($sformatf("stream%0d_fill", k), 64'(o_fill), 64'd1);
      chk($sformatf("stream%0d_pc", k),   64'(o_pc),   64'(24'h400 + k));
    end

    // Flush mid-stream: the flushed-cycle push must never appear.
    drive(1, 1, 0, 24'h0, 0, 0);
    drive(1, 0, 1, 24'h500, 0, 0);
    drive(1, 0, 1, 24'h501, 0, 0);
    drive(1, 0, 1, 24'h502, 0, 0);
    check_state("fl_pre", 1, 3, 1, 24'h500, 0);
    drive(1, 1, 1, 24'h503, 0, 1);
    check_state("fl_post", 0, 0, 1, 24'h0, 0);
    drive(1, 0, 1, 24'h200, 0, 0);
    check_state("fl_200", 1, 1, 1, 24'h200, 0);
    drive(1, 0, 0, 24'h0, 0, 1);
    check_state("fl_empty", 0, 0, 1, 24'h0, 0);

    // Simultaneous push and pop at full-minus-one.
    drive(1, 1, 0, 24'h0, 0, 0);
    drive(1, 0, 1, 24'h600, 0, 0);
    drive(1, 0, 1, 24'h601, 0, 0);
    drive(1, 0, 1, 24'h602, 0, 0);
    drive(1, 0, 1, 24'h603, 0, 1);
    check_state("pp_same", 1, 3, 1, 24'h601, 0);
    drive(1, 0, 0, 24'h0, 0, 1);
    check_state("pp_d602", 1, 2, 1, 24'h602, 0);
    drive(1, 0, 0, 24'h0, 0, 1);
    check_state("pp_d603", 1, 1, 1, 24'h603, 0);
    drive(1, 0, 0, 24'h0, 0, 1);
    check_state("pp_empty", 0, 0, 1, 24'h0, 0);

    // Reset mid-operation with a push presented.
    drive(1, 0, 1, 24'h700, 0, 0);
    drive(1, 0, 1, 24'h701, 1, 0);
    check_state("rs_pre", 1, 2, 0, 24'h700, 0);
    drive(0, 0, 1, 24'h702, 0, 1);
    check_state("rs_reset", 0, 0, 1, 24'h0, 0);
    drive(1, 0, 0, 24'h0, 0, 0);
    check_state("rs_after", 0, 0, 1, 24'h0, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      i_rst_n   = ($urandom_range(99) != 0);
      i_flush   = ($urandom_range(24) == 0);
      i_v       = ($urandom_range(3) != 0);
      i_illegal = ($urandom_range(19) == 0);
      i_stall_n = ($urandom_range(2) != 0);
      i_pc      = AW'($urandom);
      i_i       = $urandom;
      step();
      compare_model($sformatf("rnd%0d", k));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
